// File: rtl/tbcc_pkg.sv
// tbcc_pkg: shared generator constants, constraint length, FSM states and mode
// encodings for the K=7 rate-1/3 convolutional encoder.
package tbcc_pkg;
   localparam int K = 7;
   localparam logic [K-1:0] G0 = 7'o133;
   localparam logic [K-1:0] G1 = 7'o171;
   localparam logic [K-1:0] G2 = 7'o165;
   localparam logic MODE_TB = 1'b0;
   localparam logic MODE_ZT = 1'b1;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DRAIN} state_t;
   // Taps are ordered {u, s1, s2, s3, s4, s5, s6}, so the generator MSB is the current bit.
   function automatic logic conv_bit(input logic [K-1:0] v, input logic [K-1:0] g);
      return ^(v & g);
   endfunction
endpackage

// File: rtl/tbcc_bit_packer.sv
// tbcc_bit_packer: packs a serial bit stream MSB first into OUT_W-bit words,
// zero-padding and flagging the final word of a block.
module tbcc_bit_packer #(
   parameter int OUT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic             i_bit,
   input  logic             i_last,
   input  logic             i_ready,
   output logic [OUT_W-1:0] o_data,
   output logic             o_valid,
   output logic             o_last
);
   localparam int CW = $clog2(OUT_W + 1);
   localparam logic [CW-1:0] C_MAX = CW'(OUT_W - 1);
   logic [OUT_W-1:0] r_acc, r_data, w_word;
   logic [CW-1:0] r_cnt;
   logic r_valid, r_last, w_flush;
   // Bits land directly in their final position, so untouched LSBs are the padding.
   assign w_word  = r_acc | (OUT_W'(i_bit) << (C_MAX - r_cnt));
   assign w_flush = (r_cnt == C_MAX) || i_last;
   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_last  = r_last;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc   <= '0;
         r_cnt   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
         end
         if (i_en && w_flush) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_data  <= w_word;
            r_valid <= 1'b1;
            r_last  <= i_last;
         end else if (i_en) begin
            r_acc <= w_word;
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end
endmodule

// File: rtl/tbcc_encoder_par.sv
// tbcc_encoder_par: K=7 rate-1/3 convolutional encoder (133/171/165) with
// tail-biting or zero-tail termination and word-wide in/out handshakes.
module tbcc_encoder_par
   import tbcc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int OUT_W  = 8,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [LEN_W-1:0]  len_bits,
   input  logic [5:0]        tail,
   output logic              busy,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [OUT_W-1:0]  out_d0,
   output logic [OUT_W-1:0]  out_d1,
   output logic [OUT_W-1:0]  out_d2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              done
);
   localparam int BW = $clog2(DATA_W + 1);
   state_t r_state, w_next;
   logic r_mode, r_done;
   logic [LEN_W:0] r_len, r_total, r_bits, r_req, w_bits_n;
   logic [DATA_W-1:0] r_buf;
   logic [BW-1:0] r_bcnt;
   logic [5:0] r_sr;
   logic [2:0] w_valid, w_last_o;
   logic w_cap, w_ostall, w_adv, w_u, w_last, w_data_end, w_end, w_last_fire;
   logic w_d0, w_d1, w_d2;
   assign w_cap       = (r_state == S_IDLE) && start && (len_bits != '0) &&
                        ((len_bits % LEN_W'(DATA_W)) == '0);
   assign w_ostall    = out_valid && !out_ready;
   assign w_bits_n    = r_bits + (LEN_W+1)'(1);
   assign w_data_end  = w_bits_n == r_len;
   assign w_end       = w_bits_n == r_total;
   assign w_last_fire = out_valid && out_ready && out_last;
   assign w_d0        = conv_bit({w_u, r_sr}, G0);
   assign w_d1        = conv_bit({w_u, r_sr}, G1);
   assign w_d2        = conv_bit({w_u, r_sr}, G2);
   assign out_valid   = &w_valid;
   assign out_last    = &w_last_o;
   assign done        = r_done;
   always_ff @(posedge clk) r_state <= reset ? S_IDLE : w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_cap ? S_RUN : S_IDLE;
         S_RUN:   w_next = (w_adv && w_data_end) ? ((r_mode == MODE_ZT) ? S_FLUSH : S_DRAIN) : S_RUN;
         S_FLUSH: w_next = (w_adv && w_end) ? S_DRAIN : S_FLUSH;
         S_DRAIN: w_next = w_last_fire ? S_IDLE : S_DRAIN;
         default: w_next = S_IDLE;
      endcase
   end
   always_comb begin
      busy     = r_state != S_IDLE;
      in_ready = (r_state == S_RUN) && (r_bcnt == '0) && (r_req < r_len) && !w_ostall;
      w_adv    = !w_ostall && (((r_state == S_RUN) && (r_bcnt != '0)) || (r_state == S_FLUSH));
      w_u      = (r_state == S_RUN) && r_buf[DATA_W-1];
      w_last   = w_adv && w_end;
   end
   // s1 sits at r_sr[5]; tail[0] is the final block bit, i.e. the newest history bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode  <= MODE_TB;
         r_len   <= '0;
         r_total <= '0;
         r_bits  <= '0;
         r_req   <= '0;
         r_buf   <= '0;
         r_bcnt  <= '0;
         r_sr    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_last_fire;
         if (w_cap) begin
            r_mode  <= mode;
            r_len   <= {1'b0, len_bits};
            r_total <= (mode == MODE_ZT) ? {1'b0, len_bits} + (LEN_W+1)'(K - 1) : {1'b0, len_bits};
            r_bits  <= '0;
            r_req   <= '0;
            r_bcnt  <= '0;
            r_sr    <= (mode == MODE_TB) ? {tail[0], tail[1], tail[2], tail[3], tail[4], tail[5]} : 6'd0;
         end
         if (in_valid && in_ready) begin
            r_buf  <= in_data;
            r_bcnt <= BW'(DATA_W);
            r_req  <= r_req + (LEN_W+1)'(DATA_W);
         end
         if (w_adv) begin
            r_sr   <= {w_u, r_sr[5:1]};
            r_bits <= w_bits_n;
            if (r_state == S_RUN) begin
               r_buf  <= r_buf << 1;
               r_bcnt <= r_bcnt - BW'(1);
            end
         end
      end
   end
   tbcc_bit_packer #(.OUT_W(OUT_W)) u_pack0 (
      .clk(clk), .reset(reset), .i_en(w_adv), .i_bit(w_d0), .i_last(w_last), .i_ready(out_ready),
      .o_data(out_d0), .o_valid(w_valid[0]), .o_last(w_last_o[0])
   );
   tbcc_bit_packer #(.OUT_W(OUT_W)) u_pack1 (
      .clk(clk), .reset(reset), .i_en(w_adv), .i_bit(w_d1), .i_last(w_last), .i_ready(out_ready),
      .o_data(out_d1), .o_valid(w_valid[1]), .o_last(w_last_o[1])
   );
   tbcc_bit_packer #(.OUT_W(OUT_W)) u_pack2 (
      .clk(clk), .reset(reset), .i_en(w_adv), .i_bit(w_d2), .i_last(w_last), .i_ready(out_ready),
      .o_data(out_d2), .o_valid(w_valid[2]), .o_last(w_last_o[2])
   );
endmodule
